toggle_event_decoder: RTL and testbench
=======================================

# toggle_event_decoder

Receiver for the debounced toggle lines of the button/sensor front end: each debounced press flips one level signal, and this block turns each flip into a single coded event. Events are queued in a small FIFO and handed to the main state machine over a valid/ready handshake. It sits between the button front end and the pet-state/mode controller. That controller then no longer needs one edge detector per button, and no press is lost while the controller is busy.

## Interface
- FIFO_DEPTH, 4, event queue depth; power of two, ≥2
- SYNC_STAGES, 2, synchronizer flops per toggle input; ≥2
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- senal_test  in  1  toggle line, test button
- senal_energia  in  1  toggle line, energy button
- senal_medicina  in  1  toggle line, medicine button
- senal_fot  in  1  toggle line, photocell sensor
- senal_ultrasonido  in  1  toggle line, ultrasonic sensor
- evt_ready  in  1  consumer accepts head event this cycle
- evt_valid  out  1  FIFO non-empty; head event presented
- evt_code  out  3  head event code: 1 test, 2 energia, 3 medicina, 4 fot, 5 ultrasonido; 0 when empty
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky flag: at least one event dropped since reset
- drop_count  out  8  saturating count of dropped events

## Operation
- Each input passes through a SYNC_STAGES-flop synchronizer. A `prev` register holds the last synchronized value per input.
- Edge detect: edge = sync_out XOR prev. Both rising and falling transitions count as one event.
- The state machine has two states.
  - ARM: entered on reset. Counts SYNC_STAGES+1 cycles. `prev` tracks sync_out and edges are ignored, so input levels present at reset never produce events. Then moves to RUN.
  - RUN: edges set per-source pending bits. Stays in RUN until reset.
- Pending bits, one per source:
  - An edge on a source whose pending bit is clear sets the bit.
  - An edge on a source whose pending bit is already set and not being cleared this cycle is a drop.
- Push rule: each cycle, if any bit is pending and the FIFO is not full, the highest-priority pending source is pushed and its bit is cleared.
  - Priority order: test > energia > medicina > fot > ultrasonido.
  - If a new edge arrives on the same source in the cycle its bit clears, the bit stays set. This is a new event, not a drop.
- FIFO is show-ahead. Pop when evt_valid && evt_ready.
- When the FIFO is full, no push occurs, even if a pop happens in the same cycle. Pending bits hold their value.
- Drop: overflow is set, and drop_count increments, saturating at 255. Two drops in the same cycle add 2.

## Timing
- Reset values:
  - evt_valid=0, evt_code=0, fifo_full=0, overflow=0, drop_count=0.
  - FIFO empty, pending bits 0, synchronizers and `prev` at 0, state ARM.
- Assertion of reset takes effect asynchronously. Reset asserted mid-operation discards all queued and pending events.
- Latency: a toggle first sampled at edge N sets its pending bit at edge N+SYNC_STAGES. With an empty FIFO and no higher-priority pending bit, evt_valid rises after edge N+SYNC_STAGES+1, i.e. 3 cycles with defaults.
- Throughput: at most one push and one pop per cycle. With evt_ready held high, simultaneous edges on k sources appear on k consecutive cycles in priority order.
- Pop takes effect at the clock edge. The next entry is presented the same cycle the pop completes.

## Configuration
- DROP_COUNT_EN defined: the 8-bit saturating drop_count register is built.
- DROP_COUNT_EN undefined: drop_count is tied to 8'd0. The overflow flag and the drop rules are unchanged.

## Test plan
- Reset with senal_energia=1 held through ARM -> no event. Then senal_energia 1→0 -> evt_valid after 3 cycles, evt_code=2.
- senal_test and senal_ultrasonido toggle in the same cycle, evt_ready=1 -> codes 1 then 5 on consecutive cycles, then evt_valid=0.
- evt_ready=0, 5 sources toggle once each, FIFO_DEPTH=4 -> FIFO holds codes 1,2,3,4 and fifo_full=1; ultrasonido stays pending. Raise evt_ready -> 1,2,3,4 popped, then 5 appears; no drop.
- evt_ready=0 with the FIFO full and medicina pending; toggle senal_medicina again -> overflow=1, drop_count=1. Drive 300 such drops -> drop_count=255.
- Reset asserted with 3 events queued -> evt_valid=0 immediately, with no clock edge. After release, no events until a new toggle.
- Build without DROP_COUNT_EN and repeat the drop scenario -> overflow=1, drop_count=0.

Source files
------------

// File: rtl/toggle_event_decoder.sv
// Turns debounced toggle lines into coded events queued in a show-ahead FIFO with a valid/ready handoff.
// Optional feature: define DROP_COUNT_EN to build the saturating drop_count register (otherwise tied to 0).
module toggle_event_decoder #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       senal_test,
  input  logic       senal_energia,
  input  logic       senal_medicina,
  input  logic       senal_fot,
  input  logic       senal_ultrasonido,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic       fifo_full,
  output logic       overflow,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] ARM_LAST = CW'(SYNC_STAGES);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {ST_ARM = 1'b0, ST_RUN = 1'b1} state_t;

  // Lowest index wins: bit 0 (test) has the highest priority.
  function automatic logic [4:0] pick_first(input logic [4:0] req);
    logic [4:0] g;
    g = 5'd0;
    for (int i = 4; i >= 0; i--) begin
      if (req[i]) g = 5'd1 << i;
      else        g = g;
    end
    return g;
  endfunction

  function automatic logic [2:0] encode(input logic [4:0] onehot);
    logic [2:0] c;
    case (onehot)
      5'b00001: c = 3'd1;
      5'b00010: c = 3'd2;
      5'b00100: c = 3'd3;
      5'b01000: c = 3'd4;
      5'b10000: c = 3'd5;
      default:  c = 3'd0;
    endcase
    return c;
  endfunction

  logic [4:0]    raw_s;
  logic [4:0]    sync_r [SYNC_STAGES];
  logic [4:0]    sync_out_s;
  logic [4:0]    prev_r;
  logic [4:0]    edge_s;
  logic [4:0]    pend_r, pend_nxt_s;
  logic [4:0]    push_sel_s;
  logic [4:0]    drop_s;
  logic [2:0]    push_code_s;
  logic          push_s, pop_s, full_s;
  state_t        state_r, state_nxt_s;
  logic [CW-1:0] arm_cnt_r, arm_cnt_nxt_s;
  logic [2:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [AW:0]   count_r, count_nxt_s;
  logic [2:0]    head_nxt_s;
  logic          evt_valid_r, fifo_full_r, overflow_r;
  logic [2:0]    evt_code_r;

  assign raw_s      = {senal_ultrasonido, senal_fot, senal_medicina, senal_energia, senal_test};
  assign sync_out_s = sync_r[SYNC_STAGES-1];

  // Input synchronizer chain and previous-value register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 5'd0;
      prev_r <= 5'd0;
    end else begin
      sync_r[0] <= raw_s;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      prev_r <= sync_out_s;
    end
  end

  // ARM lasts SYNC_STAGES+1 cycles so levels present at reset flush through without events.
  always_comb begin
    state_nxt_s   = state_r;
    arm_cnt_nxt_s = arm_cnt_r;
    case (state_r)
      ST_ARM: begin
        if (arm_cnt_r == ARM_LAST) state_nxt_s   = ST_RUN;
        else                       arm_cnt_nxt_s = arm_cnt_r + CW'(1);
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_ARM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_ARM;
      arm_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      arm_cnt_r <= arm_cnt_nxt_s;
    end
  end

  // Pending/push/drop decisions and FIFO pointer arithmetic.
  always_comb begin
    edge_s       = (state_r == ST_RUN) ? (sync_out_s ^ prev_r) : 5'd0;
    full_s       = (count_r == DEPTH_C);
    push_sel_s   = full_s ? 5'd0 : pick_first(pend_r);
    push_s       = |push_sel_s;
    push_code_s  = encode(push_sel_s);
    pop_s        = evt_valid_r & evt_ready;
    // A new edge in the same cycle a bit clears re-arms it rather than counting as a drop.
    pend_nxt_s   = (pend_r & ~push_sel_s) | edge_s;
    drop_s       = edge_s & pend_r & ~push_sel_s;
    count_nxt_s  = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    wr_ptr_nxt_s = push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
    rd_ptr_nxt_s = pop_s  ? rd_ptr_r + AW'(1) : rd_ptr_r;
    if (count_nxt_s == '0)                       head_nxt_s = 3'd0;
    else if (push_s && rd_ptr_nxt_s == wr_ptr_r) head_nxt_s = push_code_s;
    else                                         head_nxt_s = mem_r[rd_ptr_nxt_s];
  end

  // Pending bits, FIFO storage and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_r      <= 5'd0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      evt_valid_r <= 1'b0;
      evt_code_r  <= 3'd0;
      fifo_full_r <= 1'b0;
      overflow_r  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 3'd0;
    end else begin
      pend_r      <= pend_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      count_r     <= count_nxt_s;
      evt_valid_r <= (count_nxt_s != '0);
      evt_code_r  <= head_nxt_s;
      fifo_full_r <= (count_nxt_s == DEPTH_C);
      overflow_r  <= overflow_r | (|drop_s);
      if (push_s) mem_r[wr_ptr_r] <= push_code_s;
      else        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

`ifdef DROP_COUNT_EN
  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  logic [7:0] drop_count_r;
  logic [8:0] drop_sum_s;

  assign drop_sum_s = {1'b0, drop_count_r} + {6'd0, popcount5(drop_s)};

  // Saturating drop counter; simultaneous drops add together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              drop_count_r <= 8'd0;
    else if (drop_sum_s[8]) drop_count_r <= 8'hFF;
    else                    drop_count_r <= drop_sum_s[7:0];
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = 8'd0;
`endif

  assign evt_valid = evt_valid_r;
  assign evt_code  = evt_code_r;
  assign fifo_full = fifo_full_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed self-checking bench for toggle_event_decoder (default parameters).
module tb_toggle_event_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       senal_test = 1'b0, senal_energia = 1'b0, senal_medicina = 1'b0;
  logic       senal_fot = 1'b0, senal_ultrasonido = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid, fifo_full, overflow;
  logic [2:0] evt_code;
  logic [7:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef DROP_COUNT_EN
  localparam bit DC_EN = 1'b1;
`else
  localparam bit DC_EN = 1'b0;
`endif

  toggle_event_decoder #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .senal_test(senal_test), .senal_energia(senal_energia), .senal_medicina(senal_medicina),
    .senal_fot(senal_fot), .senal_ultrasonido(senal_ultrasonido),
    .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code),
    .fifo_full(fifo_full), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; senal_energia = 1'b1; evt_ready = 1'b0;
    wait_neg(2);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", evt_valid); end
    n_checks++; if (evt_code !== 3'd0) begin n_fail++; $display("FAIL rst_code got %0d exp 0", evt_code); end
    n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", fifo_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    n_checks++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_drop_count got %0d exp 0", drop_count); end
    reset = 1'b0;
    wait_neg(8);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL arm_no_event got %b exp 0", evt_valid); end
    senal_energia = 1'b0;
    wait_neg(3);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early got %b exp 0", evt_valid); end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid got %b exp 1", evt_valid); end
    n_checks++; if (evt_code !== 3'd2) begin n_fail++; $display("FAIL latency_code got %0d exp 2", evt_code); end
    evt_ready = 1'b1;
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL pop_to_empty got %b exp 0", evt_valid); end
    n_checks++; if (evt_code !== 3'd0) begin n_fail++; $display("FAIL empty_code got %0d exp 0", evt_code); end
  endtask

  task automatic test_two_sources;
    evt_ready = 1'b1;
    senal_test = ~senal_test; senal_ultrasonido = ~senal_ultrasonido;
    wait_neg(4);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin n_fail++; $display("FAIL two_first got v=%b c=%0d exp v=1 c=1", evt_valid, evt_code); end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd5) begin n_fail++; $display("FAIL two_second got v=%b c=%0d exp v=1 c=5", evt_valid, evt_code); end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL two_drain got %b exp 0", evt_valid); end
  endtask

  task automatic test_back_to_back;
    evt_ready = 1'b1;
    senal_medicina = ~senal_medicina;
    wait_neg(1);
    senal_medicina = ~senal_medicina;
    wait_neg(3);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd3) begin n_fail++; $display("FAIL b2b_first got v=%b c=%0d exp v=1 c=3", evt_valid, evt_code); end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd3) begin n_fail++; $display("FAIL b2b_second got v=%b c=%0d exp v=1 c=3", evt_valid, evt_code); end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", evt_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_no_drop got %b exp 0", overflow); end
  endtask

  task automatic test_fill;
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5};
    evt_ready = 1'b0;
    senal_test = ~senal_test; senal_energia = ~senal_energia; senal_medicina = ~senal_medicina;
    senal_fot = ~senal_fot; senal_ultrasonido = ~senal_ultrasonido;
    wait_neg(8);
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b exp 1", fifo_full); end
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd1) begin n_fail++; $display("FAIL fill_head got v=%b c=%0d exp v=1 c=1", evt_valid, evt_code); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_neg(1);
      n_checks++; if (evt_valid !== 1'b1 || evt_code !== exp_seq[i]) begin n_fail++; $display("FAIL fill_seq%0d got v=%b c=%0d exp v=1 c=%0d", i, evt_valid, evt_code, exp_seq[i]); end
    end
    wait_neg(1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL fill_drain got %b exp 0", evt_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_drop got %b exp 0", overflow); end
  endtask

  task automatic test_drop;
    evt_ready = 1'b0;
    senal_test = ~senal_test; senal_energia = ~senal_energia;
    senal_fot = ~senal_fot; senal_ultrasonido = ~senal_ultrasonido;
    wait_neg(8);
    n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL drop_setup_full got %b exp 1", fifo_full); end
    senal_medicina = ~senal_medicina;
    wait_neg(4);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL drop_pending_only got %b exp 0", overflow); end
    senal_medicina = ~senal_medicina;
    wait_neg(4);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL drop_overflow got %b exp 1", overflow); end
    n_checks++; if (drop_count !== (DC_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL drop_count1 got %0d exp %0d", drop_count, DC_EN ? 1 : 0); end
    repeat (299) begin
      senal_medicina = ~senal_medicina;
      wait_neg(1);
    end
    wait_neg(4);
    n_checks++; if (drop_count !== (DC_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL drop_saturate got %0d exp %0d", drop_count, DC_EN ? 255 : 0); end
    n_checks++; if (fifo_full !== 1'b1 || evt_code !== 3'd1) begin n_fail++; $display("FAIL drop_fifo_kept got f=%b c=%0d exp f=1 c=1", fifo_full, evt_code); end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    wait_neg(1);
    reset = 1'b0;
    wait_neg(6);
    evt_ready = 1'b0;
    senal_test = ~senal_test; senal_energia = ~senal_energia; senal_medicina = ~senal_medicina;
    wait_neg(8);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd1 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_setup got v=%b c=%0d f=%b exp v=1 c=1 f=0", evt_valid, evt_code, fifo_full); end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (evt_valid !== 1'b0 || evt_code !== 3'd0) begin n_fail++; $display("FAIL mid_async got v=%b c=%0d exp v=0 c=0", evt_valid, evt_code); end
    @(negedge clk);
    reset = 1'b0;
    wait_neg(10);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL mid_discarded got %b exp 0", evt_valid); end
    senal_fot = ~senal_fot;
    wait_neg(4);
    n_checks++; if (evt_valid !== 1'b1 || evt_code !== 3'd4) begin n_fail++; $display("FAIL mid_new_event got v=%b c=%0d exp v=1 c=4", evt_valid, evt_code); end
  endtask

  initial begin
    test_reset;
    test_two_sources;
    test_back_to_back;
    test_fill;
    test_drop;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
